exstage_mc: RTL and testbench



---
 rtl/exstage_mc_pkg.sv | 25 ++
 rtl/exstage_mc_alu_comb.sv | 53 +++++
 rtl/exstage_mc.sv | 162 ++++++++++++++++
 tb/tb_exstage_mc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/exstage_mc_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU function codes, FSM states.
package exstage_mc_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [3:0] {
      FN_ADD = 4'b0000,
      FN_SUB = 4'b0001,
      FN_AND = 4'b0010,
      FN_OR  = 4'b0011,
      FN_NOT = 4'b0100,
      FN_SRA = 4'b1000,
      FN_SRL = 4'b1001,
      FN_SLL = 4'b1010,
      FN_ROL = 4'b1100,
      FN_ROR = 4'b1101,
      FN_MUL = 4'b1111
   } alu_func_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/exstage_mc_alu_comb.sv
// Purely combinational single-cycle ALU; mul and unknown codes yield 0 here.
module alu_comb
   import exstage_mc_pkg::*;
#(
   parameter int unsigned W = DATA_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [3:0]   func_i,
   output logic [W-1:0] result_o,
   output logic         ovf_o
);

   localparam int unsigned SH_W = $clog2(W);

   logic [SH_W-1:0] sh;
   logic [W-1:0]    sum;
   logic [W-1:0]    diff;
   logic [2*W-1:0]  rol_w;
   logic [2*W-1:0]  ror_w;

   assign sh    = b_i[SH_W-1:0];
   assign sum   = a_i + b_i;
   assign diff  = a_i - b_i;
   // Rotates via a doubled word so a zero amount needs no special case.
   assign rol_w = {a_i, a_i} << sh;
   assign ror_w = {a_i, a_i} >> sh;

   always_comb begin
      result_o = '0;
      ovf_o    = 1'b0;
      case (alu_func_e'(func_i))
         FN_ADD: begin
            result_o = sum;
            ovf_o    = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
         end
         FN_SUB: begin
            result_o = diff;
            ovf_o    = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
         end
         FN_AND:  result_o = a_i & b_i;
         FN_OR:   result_o = a_i | b_i;
         FN_NOT:  result_o = ~a_i;
         FN_SRA:  result_o = W'($signed(a_i) >>> sh);
         FN_SRL:  result_o = a_i >> sh;
         FN_SLL:  result_o = a_i << sh;
         FN_ROL:  result_o = rol_w[2*W-1:W];
         FN_ROR:  result_o = ror_w[W-1:0];
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/exstage_mc.sv
// Execute stage feeding MEMSTAGE: single-cycle ALU ops plus an iterative shift-add multiplier.
module exstage_mc
   import exstage_mc_pkg::*;
#(
   parameter int unsigned DW = DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] RF_A,
   input  logic [DW-1:0] RF_B,
   input  logic [DW-1:0] Immed,
   input  logic          ALU_Bin_sel,
   input  logic [3:0]    ALU_func,
   input  logic [5:0]    opcode_in,
   input  logic          Mem_WrEn_in,
   output logic [DW-1:0] ALU_out,
   output logic [DW-1:0] MEM_DataIn,
   output logic [5:0]    opcode_out,
   output logic          Mem_WrEn_out,
   output logic          Zero,
   output logic          Ovf,
   output logic          out_valid,
   output logic          busy
);

   localparam int unsigned CNT_W = $clog2(DW);

   state_e            state_q, state_d;
   logic [DW-1:0]     alu_out_q, alu_out_d;
   logic [DW-1:0]     mem_data_q, mem_data_d;
   logic [5:0]        opcode_q, opcode_d;
   logic              wren_q, wren_d;
   logic              wren_pend_q, wren_pend_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [DW-1:0]     mcand_q, mcand_d;
   logic [DW-1:0]     mplier_q, mplier_d;
   logic [DW-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DW-1:0]     b_sel;
   logic [DW-1:0]     alu_res;
   logic              alu_ovf;
   logic [DW-1:0]     acc_next;

   assign b_sel    = ALU_Bin_sel ? Immed : RF_B;
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

   alu_comb #(.W(DW)) u_alu (
      .a_i      (RF_A),
      .b_i      (b_sel),
      .func_i   (ALU_func),
      .result_o (alu_res),
      .ovf_o    (alu_ovf)
   );

   // Next-state and datapath updates; valid/store strobe default low so they pulse one cycle.
   always_comb begin
      state_d     = state_q;
      alu_out_d   = alu_out_q;
      mem_data_d  = mem_data_q;
      opcode_d    = opcode_q;
      wren_d      = 1'b0;
      wren_pend_d = wren_pend_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      valid_d     = 1'b0;
      busy_d      = busy_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mem_data_d = RF_B;
               opcode_d   = opcode_in;
               if (alu_func_e'(ALU_func) == FN_MUL) begin
                  mcand_d     = RF_A;
                  mplier_d    = b_sel;
                  acc_d       = '0;
                  cnt_d       = '0;
                  busy_d      = 1'b1;
                  wren_pend_d = Mem_WrEn_in;
                  state_d     = ST_MUL;
               end else begin
                  alu_out_d = alu_res;
                  zero_d    = (alu_res == '0);
                  ovf_d     = alu_ovf;
                  valid_d   = 1'b1;
                  wren_d    = Mem_WrEn_in;
               end
            end
         end
         ST_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DW - 1)) begin
               alu_out_d = acc_next;
               zero_d    = (acc_next == '0);
               ovf_d     = 1'b0;
               busy_d    = 1'b0;
               valid_d   = 1'b1;
               wren_d    = wren_pend_q;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         alu_out_q   <= '0;
         mem_data_q  <= '0;
         opcode_q    <= '0;
         wren_q      <= 1'b0;
         wren_pend_q <= 1'b0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         alu_out_q   <= alu_out_d;
         mem_data_q  <= mem_data_d;
         opcode_q    <= opcode_d;
         wren_q      <= wren_d;
         wren_pend_q <= wren_pend_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready     = ~busy_q;
   assign ALU_out      = alu_out_q;
   assign MEM_DataIn   = mem_data_q;
   assign opcode_out   = opcode_q;
   assign Mem_WrEn_out = wren_q;
   assign Zero         = zero_q;
   assign Ovf          = ovf_q;
   assign out_valid    = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_exstage_mc.sv
// Directed bench for exstage_mc: ALU ops, store path, multiplier stall and reset abort.
module tb_exstage_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] RF_A, RF_B, Immed;
   logic        ALU_Bin_sel;
   logic [3:0]  ALU_func;
   logic [5:0]  opcode_in;
   logic        Mem_WrEn_in;
   logic [31:0] ALU_out, MEM_DataIn;
   logic [5:0]  opcode_out;
   logic        Mem_WrEn_out, Zero, Ovf, out_valid, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   exstage_mc dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .RF_A         (RF_A),
      .RF_B         (RF_B),
      .Immed        (Immed),
      .ALU_Bin_sel  (ALU_Bin_sel),
      .ALU_func     (ALU_func),
      .opcode_in    (opcode_in),
      .Mem_WrEn_in  (Mem_WrEn_in),
      .ALU_out      (ALU_out),
      .MEM_DataIn   (MEM_DataIn),
      .opcode_out   (opcode_out),
      .Mem_WrEn_out (Mem_WrEn_out),
      .Zero         (Zero),
      .Ovf          (Ovf),
      .out_valid    (out_valid),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic sel, input logic [3:0] fn, input logic [5:0] op,
                         input logic wr);
      RF_A = a; RF_B = b; Immed = imm; ALU_Bin_sel = sel;
      ALU_func = fn; opcode_in = op; Mem_WrEn_in = wr;
   endtask

   // Present one instruction for a single edge (accepted when idle).
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic sel, input logic [3:0] fn, input logic [5:0] op,
                        input logic wr);
      set_op(a, b, imm, sel, fn, op, wr);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int early_valid;
      reset = 1'b1;
      in_valid = 1'b0;
      set_op(32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 6'd0, 1'b0);
      step();
      step();
      reset = 1'b0;
      chk("rst_alu_out",  ALU_out,   32'd0);
      chk("rst_zero",     32'(Zero), 32'd1);
      chk("rst_valid",    32'(out_valid), 32'd0);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      issue(32'd5, 32'd7, 32'd0, 1'b0, 4'b0000, 6'd1, 1'b0);
      chk("add_result", ALU_out, 32'd12);
      chk("add_zero",   32'(Zero), 32'd0);
      chk("add_valid",  32'(out_valid), 32'd1);
      step();
      chk("add_valid_drop", 32'(out_valid), 32'd0);
      chk("add_hold",       ALU_out, 32'd12);

      issue(32'h10, 32'h2AA, 32'h10, 1'b1, 4'b0001, 6'b000111, 1'b1);
      chk("st_result", ALU_out, 32'd0);
      chk("st_zero",   32'(Zero), 32'd1);
      chk("st_data",   MEM_DataIn, 32'h2AA);
      chk("st_opcode", 32'(opcode_out), 32'd7);
      chk("st_wren",   32'(Mem_WrEn_out), 32'd1);
      step();
      chk("st_wren_drop", 32'(Mem_WrEn_out), 32'd0);
      chk("st_data_hold", MEM_DataIn, 32'h2AA);

      issue(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0000, 6'd2, 1'b0);
      chk("ovf_result", ALU_out, 32'h8000_0000);
      chk("ovf_flag",   32'(Ovf), 32'd1);

      // Back-to-back single-cycle ops keep out_valid high.
      set_op(32'h8000_0001, 32'd4, 32'd0, 1'b0, 4'b1100, 6'd3, 1'b0);
      in_valid = 1'b1;
      step();
      chk("rol_result", ALU_out, 32'h0000_0018);
      chk("rol_ovf",    32'(Ovf), 32'd0);
      set_op(32'h8000_0000, 32'd4, 32'd0, 1'b0, 4'b1000, 6'd3, 1'b0);
      step();
      chk("sra_result", ALU_out, 32'hF800_0000);
      chk("b2b_valid",  32'(out_valid), 32'd1);
      set_op(32'h0000_00F1, 32'd0, 32'd8, 1'b1, 4'b1101, 6'd3, 1'b0);
      step();
      chk("ror_result", ALU_out, 32'hF100_0000);
      set_op(32'd9, 32'd3, 32'd0, 1'b0, 4'b0101, 6'd3, 1'b0);
      step();
      chk("undef_result", ALU_out, 32'd0);
      chk("undef_zero",   32'(Zero), 32'd1);
      in_valid = 1'b0;
      step();

      // Multiply with a store request; an add is held on the inputs through the stall.
      issue(32'd1234, 32'd5678, 32'd0, 1'b0, 4'b1111, 6'd9, 1'b1);
      chk("mul_busy",     32'(busy), 32'd1);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_st_data",  MEM_DataIn, 32'd5678);
      chk("mul_opcode",   32'(opcode_out), 32'd9);
      set_op(32'd3, 32'd4, 32'd0, 1'b0, 4'b0000, 6'd4, 1'b0);
      in_valid = 1'b1;
      busy_cycles = 1;
      early_valid = 0;
      for (int i = 0; i < 31; i++) begin
         step();
         if (busy) busy_cycles++;
         if (out_valid) early_valid++;
      end
      chk("mul_busy_cycles", 32'(busy_cycles), 32'd32);
      chk("mul_no_early",    32'(early_valid), 32'd0);
      step();
      chk("mul_valid",   32'(out_valid), 32'd1);
      chk("mul_product", ALU_out, 32'd7006652);
      chk("mul_busy_off", 32'(busy), 32'd0);
      chk("mul_wren",    32'(Mem_WrEn_out), 32'd1);
      chk("mul_ovf",     32'(Ovf), 32'd0);
      step();
      chk("held_add_result", ALU_out, 32'd7);
      chk("held_add_valid",  32'(out_valid), 32'd1);
      chk("held_add_wren",   32'(Mem_WrEn_out), 32'd0);
      in_valid = 1'b0;
      step();

      // Reset mid-multiply discards the product.
      issue(32'd1234, 32'd5678, 32'd0, 1'b0, 4'b1111, 6'd9, 1'b0);
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_busy",  32'(busy), 32'd0);
      chk("abort_alu",   ALU_out, 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      early_valid = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_valid) early_valid++;
      end
      chk("abort_no_product", 32'(early_valid), 32'd0);
      issue(32'd1, 32'd1, 32'd0, 1'b0, 4'b0000, 6'd1, 1'b0);
      chk("post_abort_add", ALU_out, 32'd2);
      chk("post_abort_valid", 32'(out_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
